// File: rtl/mod_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mod_arbiter
// Brief    : Round-robin arbiter sharing one iterative A mod B unit between
//            two level-request clients; divide-by-zero is answered locally.
// Revision : 1.0 - initial release
// ============================================================================
module mod_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0,
    input  logic             req1,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    output logic             ack0,
    output logic             ack1,
    output logic [WIDTH-1:0] result,
    output logic             dz,
    output logic             busy,
    output logic             mu_start,
    output logic [WIDTH-1:0] mu_a,
    output logic [WIDTH-1:0] mu_b,
    input  logic             mu_done,
    input  logic [WIDTH-1:0] mu_result
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_WAIT   = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    state_t           r_state;
    logic             r_last;
    logic             r_owner;
    logic [WIDTH-1:0] r_op_a;
    logic [WIDTH-1:0] r_op_b;
    logic [WIDTH-1:0] r_result;
    logic             r_dz;
    logic             r_ack0;
    logic             r_ack1;
    logic             r_busy;
    logic             r_mu_start;

    logic             w_any_req;
    logic             w_pick1;
    logic [WIDTH-1:0] w_a_sel;
    logic [WIDTH-1:0] w_b_sel;
    logic             w_b_zero;
    logic             w_mu_drive;

    // Requester 1 wins when alone, or when both ask and 0 was served last.
    assign w_any_req  = req0 | req1;
    assign w_pick1    = req1 & (~req0 | ~r_last);
    assign w_a_sel    = w_pick1 ? a1 : a0;
    assign w_b_sel    = w_pick1 ? b1 : b0;
    assign w_b_zero   = (w_b_sel == '0);
    assign w_mu_drive = (r_state == ST_LAUNCH) || (r_state == ST_WAIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_last     <= 1'b1;
            r_owner    <= 1'b0;
            r_op_a     <= '0;
            r_op_b     <= '0;
            r_result   <= '0;
            r_dz       <= 1'b0;
            r_ack0     <= 1'b0;
            r_ack1     <= 1'b0;
            r_busy     <= 1'b0;
            r_mu_start <= 1'b0;
        end else begin
            r_ack0     <= 1'b0;
            r_ack1     <= 1'b0;
            r_mu_start <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_any_req) begin
                        r_owner <= w_pick1;
                        r_op_a  <= w_a_sel;
                        r_op_b  <= w_b_sel;
                        r_busy  <= 1'b1;
                        if (w_b_zero) begin
                            // Zero divisor never reaches the shared unit.
                            r_result <= '0;
                            r_dz     <= 1'b1;
                            r_ack0   <= ~w_pick1;
                            r_ack1   <= w_pick1;
                            r_state  <= ST_RESP;
                        end else begin
                            r_mu_start <= 1'b1;
                            r_state    <= ST_LAUNCH;
                        end
                    end
                end
                ST_LAUNCH: begin
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (mu_done) begin
                        r_result <= mu_result;
                        r_dz     <= 1'b0;
                        r_ack0   <= ~r_owner;
                        r_ack1   <= r_owner;
                        r_state  <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    r_last  <= r_owner;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign ack0     = r_ack0;
    assign ack1     = r_ack1;
    assign result   = r_result;
    assign dz       = r_dz;
    assign busy     = r_busy;
    assign mu_start = r_mu_start;
    assign mu_a     = w_mu_drive ? r_op_a : '0;
    assign mu_b     = w_mu_drive ? r_op_b : '0;

endmodule
`default_nettype wire

// File: tb/tb_mod_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mod_arbiter
// Brief    : Directed self-checking bench for mod_arbiter with a behavioural
//            iterative mod unit of programmable latency.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mod_arbiter;

    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             req0, req1;
    logic [WIDTH-1:0] a0, b0, a1, b1;
    logic             ack0, ack1;
    logic [WIDTH-1:0] result;
    logic             dz, busy, mu_start;
    logic [WIDTH-1:0] mu_a, mu_b;
    logic             mu_done;
    logic [WIDTH-1:0] mu_result;

    logic             model_done = 1'b0;
    logic             stray_done;
    logic [WIDTH-1:0] model_res = '0;
    int               mu_lat;
    int               cnt = 0;

    int n_cmp = 0;
    int n_bad = 0;
    int ack0_cnt = 0;
    int ack1_cnt = 0;
    int start_cnt = 0;
    int overlap = 0;

    int k, who, s, c0, c1;
    int seq [4];

    mod_arbiter #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req0      (req0),
        .req1      (req1),
        .a0        (a0),
        .b0        (b0),
        .a1        (a1),
        .b1        (b1),
        .ack0      (ack0),
        .ack1      (ack1),
        .result    (result),
        .dz        (dz),
        .busy      (busy),
        .mu_start  (mu_start),
        .mu_a      (mu_a),
        .mu_b      (mu_b),
        .mu_done   (mu_done),
        .mu_result (mu_result)
    );

    always #5 clk = ~clk;

    // Mod unit: answers mu_lat cycles after seeing mu_start, using the
    // operands presented at completion time.
    always @(negedge clk) begin
        model_done = 1'b0;
        if (cnt > 0) begin
            cnt = cnt - 1;
            if (cnt == 0) begin
                model_done = 1'b1;
                model_res  = (mu_b != '0) ? (mu_a % mu_b) : '0;
            end
        end
        if (mu_start) cnt = mu_lat;
    end

    assign mu_done   = model_done | stray_done;
    assign mu_result = model_res;

    always @(posedge clk) begin
        if (ack0) ack0_cnt <= ack0_cnt + 1;
        if (ack1) ack1_cnt <= ack1_cnt + 1;
        if (ack0 && ack1) overlap <= overlap + 1;
        if (mu_start) start_cnt <= start_cnt + 1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic wait_ack(input int which, input int k0, output int kk);
        kk = -1;
        for (int i = k0 + 1; i <= 60; i++) begin
            @(negedge clk);
            if ((which == 0 && ack0) || (which == 1 && ack1)) begin
                kk = i;
                break;
            end
        end
    endtask

    task automatic wait_any(output int w, output int kk);
        w  = 2;
        kk = -1;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            if (ack0 || ack1) begin
                w  = ack1 ? 1 : 0;
                kk = i;
                break;
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0;
        a0 = '0; b0 = '0; a1 = '0; b1 = '0;
        stray_done = 1'b0; mu_lat = 1;
        repeat (3) @(negedge clk);
        check("rst_ack0", ack0, 0);
        check("rst_ack1", ack1, 0);
        check("rst_busy", busy, 0);
        check("rst_mu_start", mu_start, 0);
        check("rst_result", result, 0);
        check("rst_dz", dz, 0);
        check("rst_mu_a", mu_a, 0);
        check("rst_mu_b", mu_b, 0);
        rst_n = 1'b1;

        // Stray completion while idle.
        @(negedge clk); stray_done = 1'b1;
        @(negedge clk); stray_done = 1'b0;
        check("idle_stray_busy", busy, 0);

        // Simultaneous requests right after reset: 0 wins, then 1.
        mu_lat = 1;
        a0 = 100; b0 = 7; a1 = 9; b1 = 4;
        req0 = 1'b1; req1 = 1'b1;
        wait_ack(0, 0, k);
        check("rr_first_lat", k, 3);
        check("rr_first_res", result, 2);
        check("rr_first_ack1", ack1, 0);
        req0 = 1'b0;
        wait_ack(1, 0, k);
        check("rr_second_lat", k, 4);
        check("rr_second_res", result, 1);
        check("rr_second_dz", dz, 0);
        req1 = 1'b0;

        // Back-to-back contention; the served requester re-asks at once.
        @(negedge clk);
        a0 = 50; b0 = 6; a1 = 33; b1 = 10;
        req0 = 1'b1; req1 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wait_any(who, k);
            seq[i] = who;
            check("contend_res", result, (who == 1) ? 3 : 2);
            if (who == 0) req0 = 1'b0;
            else if (who == 1) req1 = 1'b0;
            if (i < 2) begin
                @(negedge clk);
                if (who == 0) req0 = 1'b1;
                else if (who == 1) req1 = 1'b1;
            end
        end
        check("contend_g0", seq[0], 0);
        check("contend_g1", seq[1], 1);
        check("contend_g2", seq[2], 0);
        check("contend_g3", seq[3], 1);

        // Zero divisor on requester 1.
        @(negedge clk);
        s = start_cnt;
        a1 = 123; b1 = 0; req1 = 1'b1;
        wait_ack(1, 0, k);
        check("dz_lat", k, 1);
        check("dz_res", result, 0);
        check("dz_flag", dz, 1);
        check("dz_ack0", ack0, 0);
        req1 = 1'b0; b1 = 4;
        @(negedge clk);
        check("dz_no_start", start_cnt - s, 0);
        check("dz_busy_after", busy, 0);

        // Single request, 4-cycle unit, stray done during LAUNCH.
        mu_lat = 4; s = start_cnt; c1 = ack1_cnt;
        a0 = 17; b0 = 5; req0 = 1'b1;
        @(negedge clk);
        check("s1_busy", busy, 1);
        check("s1_start", mu_start, 1);
        check("s1_mu_a", mu_a, 17);
        check("s1_mu_b", mu_b, 5);
        stray_done = 1'b1;
        @(negedge clk);
        stray_done = 1'b0;
        check("s1_start_once", mu_start, 0);
        check("s1_mu_a_wait", mu_a, 17);
        wait_ack(0, 2, k);
        check("s1_lat", k, 6);
        check("s1_res", result, 2);
        check("s1_dz", dz, 0);
        req0 = 1'b0;
        @(negedge clk);
        check("s1_ack_pulse", ack0, 0);
        check("s1_idle_busy", busy, 0);
        check("s1_idle_mu_a", mu_a, 0);
        check("s1_start_count", start_cnt - s, 1);
        check("s1_no_ack1", ack1_cnt - c1, 0);

        // Request dropped and operands changed while waiting.
        mu_lat = 3;
        a0 = 40; b0 = 9; req0 = 1'b1;
        @(negedge clk);
        @(negedge clk);
        req0 = 1'b0; a0 = 41; b0 = 2;
        @(negedge clk);
        check("drop_mu_a", mu_a, 40);
        check("drop_mu_b", mu_b, 9);
        wait_ack(0, 3, k);
        check("drop_lat", k, 5);
        check("drop_res", result, 4);

        // Reset during WAIT, stray completion afterwards, then recovery.
        @(negedge clk);
        mu_lat = 6; c0 = ack0_cnt;
        a0 = 25; b0 = 7; req0 = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b0; req0 = 1'b0;
        #1;
        check("mrst_busy", busy, 0);
        check("mrst_mu_a", mu_a, 0);
        check("mrst_result", result, 0);
        check("mrst_dz", dz, 0);
        check("mrst_ack0", ack0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("mrst_stray_busy", busy, 0);
        check("mrst_no_ack", ack0_cnt - c0, 0);
        check("mrst_stray_res", result, 0);
        mu_lat = 1;
        a1 = 30; b1 = 4; req1 = 1'b1;
        wait_ack(1, 0, k);
        check("recover_lat", k, 3);
        check("recover_res", result, 2);
        req1 = 1'b0;

        @(negedge clk);
        check("no_overlap", overlap, 0);
        check("total_ack0", ack0_cnt, 5);
        check("total_ack1", ack1_cnt, 5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mod_arbiter.md
MOD_ARBITER -- requirements
Module: mod_arbiter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, as the operand/result width in bits.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-004 The block SHALL have ports req0/req1, input, 1 each, requester N asks for A mod B; level, held until ackN.
REQ-005 The block SHALL have ports a0/b0 and a1/b1, input, WIDTH each, requester N dividend/divisor; stable while reqN is high.
REQ-006 The block SHALL have ports ack0/ack1, output, 1 each, one-cycle pulse: result/dz are valid for requester N.
REQ-007 The block SHALL have port result, output, WIDTH, registered remainder of the last completed operation.
REQ-008 The block SHALL have port dz, output, 1, registered flag: last operation had divisor zero.
REQ-009 The block SHALL have port busy, output, 1, high in every state except IDLE.
REQ-010 The block SHALL have ports mu_start (output, 1), mu_a/mu_b (output, WIDTH), mu_done (input, 1), mu_result (input, WIDTH), the shared iterative mod unit interface.

Function
REQ-011 The block SHALL implement states IDLE, LAUNCH, WAIT, RESP as a registered state machine.
REQ-012 IDLE: with no request asserted, the block SHALL remain in IDLE.
REQ-013 IDLE: when one request is high, the block SHALL grant it, latch its a/b into internal operand registers, record the owner, and leave IDLE on the same edge.
REQ-014 IDLE: when both requests are high, the block SHALL grant the requester that was not granted last (round-robin).
REQ-015 The last-grant pointer SHALL reset to 1, so req0 wins the first simultaneous contest.
REQ-016 The last-grant pointer SHALL update on leaving RESP.
REQ-017 On grant with latched b == 0, the block SHALL go directly to RESP without asserting mu_start, and SHALL set result=0, dz=1.
REQ-018 On grant with b != 0, the block SHALL go to LAUNCH.
REQ-019 LAUNCH: the block SHALL assert mu_start for exactly one cycle, then go to WAIT.
REQ-020 mu_a/mu_b SHALL equal the latched operands from LAUNCH through WAIT, and SHALL be 0 in IDLE.
REQ-021 WAIT: the block SHALL hold until mu_done=1, then capture mu_result into result, clear dz, and go to RESP.
REQ-022 mu_done outside WAIT SHALL be ignored, including mu_done in the LAUNCH cycle.
REQ-023 RESP: the block SHALL assert ack of the owner only, for exactly one cycle, then go to IDLE.
REQ-024 result and dz SHALL hold their values until the next capture.
REQ-025 Requester rule: reqN SHALL be deasserted on the edge at which ackN is sampled high; a request high in IDLE after that edge is treated as a new operation.
REQ-026 Deassertion of reqN or operand changes after grant SHALL NOT affect the in-flight operation; its ack is still delivered.
REQ-027 A request arriving while busy SHALL wait, un-acked, until the block returns to IDLE.
REQ-028 Latency (b != 0): ack SHALL occur 3 cycles after the grant edge when mu_done arrives in the first WAIT cycle, plus one cycle per extra WAIT cycle.
REQ-029 Latency (b == 0): ack SHALL occur in the cycle immediately after the grant edge.
REQ-030 ack0 and ack1 SHALL never be high together; mu_start SHALL never be high outside LAUNCH.

Reset
REQ-031 When rst_n is low, the block SHALL immediately force state=IDLE, last-grant=1, operand registers=0, result=0, dz=0, and ack0=ack1=busy=mu_start=0.
REQ-032 Reset mid-operation SHALL drop the in-flight operation without issuing an ack.
REQ-033 After reset release, the block SHALL treat any late mu_done as stray and ignore it.

Verification
REQ-034 Scenario: req0 alone with a0=17, b0=5, and the model unit returns 2 after 4 cycles -> single mu_start pulse with mu_a=17, mu_b=5; ack0 pulse; result=2, dz=0; ack1 never high.
REQ-035 Scenario: req0 and req1 rise in the same cycle after reset, with (100,7) and (9,4) -> req0 served first (result=2), then req1 (result=1); never overlapping.
REQ-036 Scenario: back-to-back contention three times -> grants alternate 0,1,0 and no requester is starved.
REQ-037 Scenario: req1 with b1=0, a1=123 -> ack1 on the cycle after grant; result=0, dz=1; mu_start never asserted.
REQ-038 Scenario: rst_n driven low during WAIT, then released -> outputs zero immediately; no ack; a stray mu_done is ignored; the next request completes normally.
REQ-039 Scenario: req0 dropped and a0 changed during WAIT -> ack0 still issued, with the result from the originally latched operands.
